// File: rtl/cnn_pkg.sv
// Shared types and constants for the convolution MAC engine.
// Build option: CONV_MAC_RELU_EN enables ReLU clamping in the requantizer.
package cnn_pkg;
  localparam int FRAC_BITS_DEF = 14;
  // One guard bit so acc + bias can never wrap before the shift.
  localparam int SUM_GUARD = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mac_lane.sv
// One output-channel MAC lane: signed multiply, first-element overwrite, accumulate.
module mac_lane #(
  parameter int WIDTH = 16,
  parameter int ACCW  = 36
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_first,
  input  logic signed [WIDTH-1:0] i_ifm,
  input  logic signed [WIDTH-1:0] i_w,
  output logic signed [ACCW-1:0]  o_acc
);
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACCW-1:0]    r_acc;

  assign w_prod = i_ifm * i_w;

  // The first element of a window overwrites, so no clear cycle is needed.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)    r_acc <= '0;
    else if (i_en) r_acc <= i_first ? ACCW'(w_prod) : r_acc + ACCW'(w_prod);
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/conv_mac_engine.sv
// Convolution MAC engine: DSP_NO parallel lanes, bias add, requantize, layer FSM.
// Build option: CONV_MAC_RELU_EN clamps negative post-shift results to zero.
module conv_mac_engine
  import cnn_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DSP_NO     = 112,
  parameter int CHIN       = 384,
  parameter int KERNEL_DIM = 3,
  parameter int WOUT       = 8,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  localparam int N  = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int AW = addr_w(N)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_layer_en,
  input  logic signed [WIDTH-1:0]        i_ifm,
  output logic [AW-1:0]                  o_weight_addr,
  input  logic [DSP_NO-1:0][WIDTH-1:0]   i_kernels,
  input  logic [DSP_NO-1:0][2*WIDTH-1:0] i_bias,
  input  logic                           i_ram_feedback,
  output logic                           o_sample,
  output logic                           o_finish,
  output logic [DSP_NO-1:0][WIDTH-1:0]   o_ofm
);
  localparam int P    = WOUT * WOUT;
  localparam int PW   = addr_w(P + 1);
  localparam int ACCW = 2 * WIDTH + $clog2(N);
  localparam int SW   = ACCW + SUM_GUARD;
  localparam logic signed [SW-1:0] W_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] W_MIN = ~W_MAX;

  state_t                        r_state, w_state_nxt;
  logic [AW-1:0]                 r_cnt, r_elem_d;
  logic [PW-1:0]                 r_pix;
  logic                          r_en_d, r_fire, r_sample, r_fb;
  logic [DSP_NO-1:0][WIDTH-1:0]  r_ofm, w_q;
  logic [DSP_NO-1:0][ACCW-1:0]   w_acc;
  logic                          w_adv, w_first, w_last;

  assign w_adv   = i_layer_en && (r_state != S_DONE);
  assign w_first = (r_elem_d == '0);
  assign w_last  = r_en_d && (r_elem_d == AW'(N-1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_layer_en) w_state_nxt = S_RUN;
      S_RUN:   if (r_fire && (r_pix == PW'(P-1))) w_state_nxt = S_DONE;
      default: ;
    endcase
  end

  // Element index is delayed one cycle to line up with ROM data and ifm.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt    <= '0;
      r_elem_d <= '0;
      r_en_d   <= 1'b0;
      r_fire   <= 1'b0;
      r_sample <= 1'b0;
      r_fb     <= 1'b0;
      r_pix    <= '0;
      r_ofm    <= '0;
    end else begin
      r_en_d   <= w_adv;
      r_fire   <= w_last;
      r_sample <= r_fire && (r_state != S_DONE);
      r_fb     <= r_fb | i_ram_feedback;
      if (w_adv) begin
        r_elem_d <= r_cnt;
        r_cnt    <= (r_cnt == AW'(N-1)) ? '0 : r_cnt + 1'b1;
      end
      if (r_fire && (r_state != S_DONE)) begin
        r_ofm <= w_q;
        r_pix <= r_pix + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
    logic signed [SW-1:0] w_sum, w_sh;
    logic [WIDTH-1:0]     w_ql;

    mac_lane #(.WIDTH(WIDTH), .ACCW(ACCW)) u_lane (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (r_en_d),
      .i_first (w_first),
      .i_ifm   (i_ifm),
      .i_w     (i_kernels[g]),
      .o_acc   (w_acc[g])
    );

    assign w_sum = SW'($signed(w_acc[g])) + SW'($signed(i_bias[g]));
    assign w_sh  = w_sum >>> FRAC_BITS;

    always_comb begin
      w_ql = w_sh[WIDTH-1:0];
      if (w_sh > W_MAX)      w_ql = W_MAX[WIDTH-1:0];
      else if (w_sh < W_MIN) w_ql = W_MIN[WIDTH-1:0];
`ifdef CONV_MAC_RELU_EN
      if (w_sh[SW-1]) w_ql = '0;
`endif
    end

    assign w_q[g] = w_ql;
  end

  assign o_weight_addr = r_cnt;
  assign o_sample      = r_sample;
  assign o_finish      = (r_state == S_DONE) && !r_fb;
  assign o_ofm         = r_ofm;
endmodule

// File: doc/conv_mac_engine.md
CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

Interface
REQ-001 Parameter WIDTH, default 16, pixel/weight/output word width in signed fixed point.
REQ-002 Parameter DSP_NO, default 112, number of parallel output channels (MAC lanes).
REQ-003 Parameter CHIN, default 384, input channels per output pixel.
REQ-004 Parameter KERNEL_DIM, default 3, square kernel side; accumulation length N = KERNEL_DIM^2*CHIN.
REQ-005 Parameter WOUT, default 8, output map side; output pixels per layer P = WOUT^2.
REQ-006 Parameter FRAC_BITS, default 14, fractional bits of WIDTH words.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 layer_en  input  1  operand-valid/advance qualifier; low stalls the engine.
REQ-010 ifm  input  WIDTH  signed input pixel, valid one cycle after its weight_addr cycle.
REQ-011 weight_addr  output  clog2(N)  registered address to external synchronous weight ROM.
REQ-012 kernels  input  DSP_NO x WIDTH  signed weights, ROM data one cycle after weight_addr.
REQ-013 bias  input  DSP_NO x 2*WIDTH  signed per-lane bias, static for the layer, scale 2*FRAC_BITS.
REQ-014 ram_feedback  input  1  downstream acknowledgement of layer completion.
REQ-015 sample  output  1  one-cycle pulse: ofm holds a new output pixel.
REQ-016 finish  output  1  layer complete and not yet acknowledged.
REQ-017 ofm  output  DSP_NO x WIDTH  registered output pixel, all lanes.

Function
REQ-018 States IDLE, RUN, DONE; IDLE->RUN on first layer_en=1; RUN->DONE on P-th sample; DONE held until reset.
REQ-019 Element counter 0..N-1 advances, and weight_addr follows it, only in cycles with layer_en=1 and state != DONE; wraps N-1 -> 0.
REQ-020 layer_en delayed one cycle (en_d) qualifies accumulation of ifm*kernels[i] into lane accumulator i.
REQ-021 Accumulator width 2*WIDTH+clog2(N) signed; first element of each window overwrites instead of adding (no separate clear cycle).
REQ-022 Stall (layer_en=0) anywhere in a window freezes counter, accumulators and weight_addr; result identical to unstalled run.
REQ-023 On the edge after the N-th accumulate: sum = acc + sign-extended bias, arithmetic shift right FRAC_BITS, saturate to signed WIDTH range, write ofm, pulse sample for exactly one cycle.
REQ-024 Pixel counter increments per sample; on reaching P enter DONE; further layer_en ignored, ofm holds last value.
REQ-025 ram_feedback latched sticky (any cycle, any state); finish = DONE and not latched; ram_feedback before DONE suppresses finish entirely.
REQ-026 Latency: sample asserted 2 cycles after the cycle presenting the last ifm/kernels of a window.

Reset
REQ-027 rst low: state IDLE, counters 0, weight_addr 0, accumulators 0, ofm all 0, sample 0, finish 0, feedback latch 0, effective immediately; mid-window reset discards partial sums.

Configuration
REQ-028 Macro CONV_MAC_RELU_EN defined: post-shift negative results clamp to 0 before saturation (ReLU); undefined: signed saturated result passed unmodified.

Structure
REQ-029 Package cnn_pkg holds FRAC_BITS default, state enum type, and saturate/shift width helper constants.
REQ-030 One sub-module mac_lane (multiply, first-element overwrite, accumulate), generated DSP_NO times; control, bias, requantization in top.

Verification (WIDTH=16, DSP_NO=4, CHIN=2, KERNEL_DIM=1, WOUT=2, FRAC_BITS=14, bias=0 unless stated)
REQ-031 ifm=16384, kernels all 8192, layer_en held high -> each ofm lane 16384, sample every 2 cycles, 4 samples, then finish=1.
REQ-032 ifm=16384, kernels 16384 -> ofm saturates to 32767; kernels -16384 -> 0 with CONV_MAC_RELU_EN, -32768 without.
REQ-033 layer_en low 3 cycles between elements 0 and 1 of window 0 -> ofm 16384 (REQ-031 stimulus), sample 3 cycles later, weight_addr frozen during stall.
REQ-034 bias lane2 = 1<<28, others 0, kernels 0 -> ofm lane2 16384, other lanes 0.
REQ-035 After 4th sample finish=1; ram_feedback pulse -> finish=0 next cycle and stays 0; layer_en toggles after DONE -> no sample, weight_addr unchanged.
REQ-036 rst asserted after element 0 of window 1 -> all outputs 0 asynchronously; restart yields 4 correct samples from pixel 0.
